// File: rtl/branch_predict_unit_pkg.sv
// Shared predictor definitions: saturating-counter helpers sized by a counter width
// argument (up to 4 bits) and the table update classification.
package branch_predict_unit_pkg;

  localparam int unsigned CTR_BITS_MAX = 4;

  typedef logic [CTR_BITS_MAX-1:0] ctr_word_t;

  typedef enum logic [1:0] {
    UPD_NONE,
    UPD_TRAIN,
    UPD_JUMP,
    UPD_ALLOC
  } upd_kind_e;

  function automatic ctr_word_t CTR_MAX(input int unsigned bits);
    return ctr_word_t'((32'd1 << bits) - 32'd1);
  endfunction

  function automatic ctr_word_t WEAK_TAKEN(input int unsigned bits);
    return ctr_word_t'(32'd1 << (bits - 32'd1));
  endfunction

  function automatic ctr_word_t CTR_INC(input ctr_word_t ctr, input int unsigned bits);
    return (ctr >= CTR_MAX(bits)) ? ctr : ctr + ctr_word_t'(1);
  endfunction

  function automatic ctr_word_t CTR_DEC(input ctr_word_t ctr);
    return (ctr == '0) ? ctr : ctr - ctr_word_t'(1);
  endfunction

  function automatic logic CTR_MSB(input ctr_word_t ctr, input int unsigned bits);
    ctr_word_t shifted;
    shifted = ctr >> (bits - 32'd1);
    return shifted[0];
  endfunction

endpackage

// File: rtl/branch_predict_unit_sat_counter.sv
// Up/down saturating counter next-state block; shared with the tournament predictor.
module sat_counter
  import branch_predict_unit_pkg::*;
#(
  parameter int unsigned CTR_BITS = 2
) (
  input  logic [CTR_BITS-1:0] ctr,
  input  logic                up,
  output logic [CTR_BITS-1:0] ctr_next
);

  ctr_word_t wide;

  always_comb begin
    wide     = ctr_word_t'(ctr);
    ctr_next = CTR_BITS'(up ? CTR_INC(wide, CTR_BITS) : CTR_DEC(wide));
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Tagged direction/target predictor: registered fetch lookup, MEM-stage resolve with
// flush/redirect generation, table training/allocation and prediction statistics.
module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int unsigned ENTRIES  = 1024,
  parameter int unsigned CTR_BITS = 2,
  parameter int unsigned TAG_BITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [31:0] pred_pc,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        res_valid,
  input  logic [31:0] res_pc,
  input  logic        res_is_branch,
  input  logic        res_is_jump,
  input  logic        res_cond,
  input  logic [31:0] res_target,
  input  logic        res_pred_taken,
  input  logic [31:0] res_pred_target,
  output logic        flush,
  output logic [31:0] redirect_pc,
  output logic [31:0] stat_total,
  output logic [31:0] stat_miss
);

  localparam int unsigned IDX   = $clog2(ENTRIES);
  localparam int unsigned TAG_W = (TAG_BITS == 0) ? 1 : TAG_BITS;

  // Untagged tables compare an all-zero tag, so any valid entry hits.
  localparam logic [TAG_W-1:0]    TAG_MASK = (TAG_BITS == 0) ? '0 : '1;
  localparam logic [CTR_BITS-1:0] CTR_FULL = CTR_BITS'(CTR_MAX(CTR_BITS));
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(WEAK_TAKEN(CTR_BITS));

  logic                valid_q  [ENTRIES];
  logic [TAG_W-1:0]    tag_q    [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];

  logic [IDX-1:0]      lk_idx;
  logic [TAG_W-1:0]    lk_tag;
  logic [IDX-1:0]      r_idx;
  logic [TAG_W-1:0]    r_tag;
  logic                pc_bits_unused;

  logic                ctl;
  logic                actual;
  logic                upd_en;
  logic                r_hit;
  logic [CTR_BITS-1:0] ctr_step;
  logic [CTR_BITS-1:0] ctr_new;
  logic                tgt_we;
  logic                upd_we;
  upd_kind_e           upd_kind;

  logic                byp;
  logic                e_valid;
  logic [TAG_W-1:0]    e_tag;
  logic [CTR_BITS-1:0] e_ctr;
  logic [31:0]         e_target;
  logic                lk_hit;

  assign lk_idx = pred_pc[IDX+1:2];
  assign r_idx  = res_pc[IDX+1:2];
  assign lk_tag = TAG_W'(pred_pc >> (IDX + 2)) & TAG_MASK;
  assign r_tag  = TAG_W'(res_pc >> (IDX + 2)) & TAG_MASK;
  assign pc_bits_unused = ^{pred_pc[1:0], res_pc[1:0]};

  // Resolve: a jump flag dominates the branch flag.
  assign ctl    = res_valid && (res_is_branch || res_is_jump);
  assign actual = res_is_jump || (res_is_branch && res_cond);
  assign upd_en = ctl && !stall && !rst;
  assign r_hit  = valid_q[r_idx] && (tag_q[r_idx] == r_tag);

  assign flush = upd_en &&
                 ((actual != res_pred_taken) || (actual && (res_target != res_pred_target)));
  assign redirect_pc = (flush && actual) ? res_target : res_pc + 32'd4;

  sat_counter #(
    .CTR_BITS (CTR_BITS)
  ) u_sat_counter (
    .ctr      (ctr_q[r_idx]),
    .up       (actual),
    .ctr_next (ctr_step)
  );

  always_comb begin
    upd_kind = UPD_NONE;
    ctr_new  = ctr_q[r_idx];
    tgt_we   = 1'b0;
    if (upd_en) begin
      if (r_hit && res_is_jump) begin
        upd_kind = UPD_JUMP;
        ctr_new  = CTR_FULL;
        tgt_we   = 1'b1;
      end else if (r_hit) begin
        upd_kind = UPD_TRAIN;
        ctr_new  = ctr_step;
        tgt_we   = actual;
      end else if (actual) begin
        upd_kind = UPD_ALLOC;
        ctr_new  = res_is_jump ? CTR_FULL : CTR_INIT;
        tgt_we   = 1'b1;
      end
    end
  end

  assign upd_we = (upd_kind != UPD_NONE);

  // Lookup sees the entry as it will be after this cycle's update (write-first bypass).
  always_comb begin
    byp      = upd_we && (r_idx == lk_idx);
    e_valid  = byp ? 1'b1    : valid_q[lk_idx];
    e_tag    = byp ? r_tag   : tag_q[lk_idx];
    e_ctr    = byp ? ctr_new : ctr_q[lk_idx];
    e_target = (byp && tgt_we) ? res_target : target_q[lk_idx];
    lk_hit   = e_valid && (e_tag == lk_tag);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pred_hit    <= 1'b0;
      pred_taken  <= 1'b0;
      pred_target <= '0;
    end else if (!stall) begin
      pred_hit    <= lk_hit;
      pred_taken  <= lk_hit && CTR_MSB(ctr_word_t'(e_ctr), CTR_BITS);
      pred_target <= lk_hit ? e_target : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (upd_we) begin
      valid_q[r_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (upd_we) begin
      tag_q[r_idx] <= r_tag;
      ctr_q[r_idx] <= ctr_new;
      if (tgt_we) begin
        target_q[r_idx] <= res_target;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_total <= '0;
      stat_miss  <= '0;
    end else if (upd_en) begin
      stat_total <= stat_total + 32'd1;
      if (flush) begin
        stat_miss <= stat_miss + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: default 2-bit instance plus a 3-bit counter
// instance sharing the same stimulus.
module tb_branch_predict_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic [31:0] pred_pc;
  logic        res_valid;
  logic [31:0] res_pc;
  logic        res_is_branch;
  logic        res_is_jump;
  logic        res_cond;
  logic [31:0] res_target;
  logic        res_pred_taken;
  logic [31:0] res_pred_target;

  logic        pred_hit, pred_taken, flush;
  logic [31:0] pred_target, redirect_pc, stat_total, stat_miss;
  logic        hit3, taken3, flush3;
  logic [31:0] target3, redirect3, total3, miss3;

  int errors = 0;
  int checks = 0;

  branch_predict_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .pred_pc(pred_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .res_valid(res_valid), .res_pc(res_pc), .res_is_branch(res_is_branch),
    .res_is_jump(res_is_jump), .res_cond(res_cond), .res_target(res_target),
    .res_pred_taken(res_pred_taken), .res_pred_target(res_pred_target),
    .flush(flush), .redirect_pc(redirect_pc),
    .stat_total(stat_total), .stat_miss(stat_miss)
  );

  branch_predict_unit #(
    .ENTRIES  (1024),
    .CTR_BITS (3),
    .TAG_BITS (8)
  ) dut3 (
    .clk(clk), .rst(rst), .stall(stall), .pred_pc(pred_pc),
    .pred_hit(hit3), .pred_taken(taken3), .pred_target(target3),
    .res_valid(res_valid), .res_pc(res_pc), .res_is_branch(res_is_branch),
    .res_is_jump(res_is_jump), .res_cond(res_cond), .res_target(res_target),
    .res_pred_taken(res_pred_taken), .res_pred_target(res_pred_target),
    .flush(flush3), .redirect_pc(redirect3),
    .stat_total(total3), .stat_miss(miss3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_res(input logic [31:0] pc, input logic br, input logic jmp,
                           input logic cond, input logic [31:0] tgt,
                           input logic ptk, input logic [31:0] ptgt);
    res_valid       = 1'b1;
    res_pc          = pc;
    res_is_branch   = br;
    res_is_jump     = jmp;
    res_cond        = cond;
    res_target      = tgt;
    res_pred_taken  = ptk;
    res_pred_target = ptgt;
  endtask

  task automatic resolve(input string tag, input logic [31:0] pc, input logic br,
                         input logic jmp, input logic cond, input logic [31:0] tgt,
                         input logic ptk, input logic [31:0] ptgt,
                         input logic exp_fl, input logic [31:0] exp_rd);
    drive_res(pc, br, jmp, cond, tgt, ptk, ptgt);
    #1;
    check({tag, ".flush"}, 32'(flush), 32'(exp_fl));
    check({tag, ".redirect"}, redirect_pc, exp_rd);
    step();
    res_valid = 1'b0;
  endtask

  task automatic quiet_res(input logic [31:0] pc, input logic cond);
    drive_res(pc, 1'b1, 1'b0, cond, 32'h0000_0680, 1'b1, 32'h0000_0680);
    step();
    res_valid = 1'b0;
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc, input logic exp_hit,
                        input logic exp_taken, input logic [31:0] exp_tgt);
    pred_pc = pc;
    step();
    check({tag, ".hit"}, 32'(pred_hit), 32'(exp_hit));
    check({tag, ".taken"}, 32'(pred_taken), 32'(exp_taken));
    check({tag, ".target"}, pred_target, exp_tgt);
  endtask

  task automatic check_stats(input string tag, input logic [31:0] t, input logic [31:0] m);
    check({tag, ".total"}, stat_total, t);
    check({tag, ".miss"}, stat_miss, m);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; pred_pc = '0; res_valid = 1'b0; res_pc = '0;
    res_is_branch = 1'b0; res_is_jump = 1'b0; res_cond = 1'b0; res_target = '0;
    res_pred_taken = 1'b0; res_pred_target = '0;

    // Reset with a would-be mispredict on the resolve port.
    step();
    drive_res(32'h40, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0);
    #1;
    check("rst_flush", 32'(flush), 32'd0);
    step();
    res_valid = 1'b0;
    rst = 1'b0;
    check("rst_hit", 32'(pred_hit), 32'd0);
    check("rst_target", pred_target, 32'h0);
    check_stats("rst_stats", 32'd0, 32'd0);

    lookup("lk_empty", 32'h40, 1'b0, 1'b0, 32'h0);
    resolve("beq_alloc", 32'h40, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0, 1'b1, 32'h80);
    lookup("lk_after_alloc", 32'h40, 1'b1, 1'b1, 32'h80);
    resolve("nt1", 32'h40, 1'b1, 1'b0, 1'b0, 32'h80, 1'b1, 32'h80, 1'b1, 32'h44);
    lookup("lk_ctr1", 32'h40, 1'b1, 1'b0, 32'h80);
    resolve("nt2", 32'h40, 1'b1, 1'b0, 1'b0, 32'h80, 1'b1, 32'h80, 1'b1, 32'h44);
    resolve("nt3", 32'h40, 1'b1, 1'b0, 1'b0, 32'h80, 1'b0, 32'h80, 1'b0, 32'h44);
    resolve("tk_from0", 32'h40, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0, 1'b1, 32'h80);
    lookup("lk_sat0", 32'h40, 1'b1, 1'b0, 32'h80);
    check_stats("stats_a", 32'd5, 32'd4);

    // Jump allocation, target retrain, and hit-jump forcing the counter to max.
    resolve("j_alloc", 32'h100, 1'b0, 1'b1, 1'b0, 32'h204, 1'b0, 32'h0, 1'b1, 32'h204);
    resolve("j_tgt", 32'h100, 1'b0, 1'b1, 1'b0, 32'h200, 1'b1, 32'h204, 1'b1, 32'h200);
    lookup("lk_jump", 32'h100, 1'b1, 1'b1, 32'h200);
    resolve("j_nt1", 32'h100, 1'b1, 1'b0, 1'b0, 32'h200, 1'b1, 32'h200, 1'b1, 32'h104);
    resolve("j_nt2", 32'h100, 1'b1, 1'b0, 1'b0, 32'h200, 1'b1, 32'h200, 1'b1, 32'h104);
    lookup("lk_j_ctr1", 32'h100, 1'b1, 1'b0, 32'h200);
    resolve("j_max", 32'h100, 1'b0, 1'b1, 1'b0, 32'h200, 1'b0, 32'h0, 1'b1, 32'h200);
    resolve("j_nt3", 32'h100, 1'b1, 1'b0, 1'b0, 32'h200, 1'b1, 32'h200, 1'b1, 32'h104);
    lookup("lk_j_ctr2", 32'h100, 1'b1, 1'b1, 32'h200);

    // Aliasing and not-taken miss (no allocation).
    lookup("lk_alias", 32'h1040, 1'b0, 1'b0, 32'h0);
    resolve("alias_nt", 32'h1040, 1'b1, 1'b0, 1'b0, 32'h99, 1'b0, 32'h0, 1'b0, 32'h1044);
    lookup("lk_alias_keep", 32'h40, 1'b1, 1'b0, 32'h80);
    resolve("wrap", 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 32'h10, 1'b1, 32'h10, 1'b1, 32'h0);

    // Same-cycle lookup and allocate.
    pred_pc = 32'h300;
    resolve("byp_res", 32'h300, 1'b1, 1'b0, 1'b1, 32'h380, 1'b0, 32'h0, 1'b1, 32'h380);
    check("byp.hit", 32'(pred_hit), 32'd1);
    check("byp.taken", 32'(pred_taken), 32'd1);
    check("byp.target", pred_target, 32'h380);
    check_stats("stats_b", 32'd14, 32'd12);

    // Stall held for three cycles during a resolve.
    lookup("lk_prestall", 32'h40, 1'b1, 1'b0, 32'h80);
    stall = 1'b1;
    pred_pc = 32'h300;
    drive_res(32'h500, 1'b1, 1'b0, 1'b1, 32'h580, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall.flush", 32'(flush), 32'd0);
      step();
      check("stall.hit", 32'(pred_hit), 32'd1);
      check("stall.taken", 32'(pred_taken), 32'd0);
      check("stall.target", pred_target, 32'h80);
    end
    stall = 1'b0;
    res_valid = 1'b0;
    check_stats("stats_stall", 32'd14, 32'd12);
    lookup("lk_stall_nowrite", 32'h500, 1'b0, 1'b0, 32'h0);

    // Saturation: 3-bit counter reaches 7, so four decrements are needed to go not-taken.
    for (int i = 0; i < 10; i++) quiet_res(32'h600, 1'b1);
    for (int i = 0; i < 3; i++) quiet_res(32'h600, 1'b0);
    pred_pc = 32'h600;
    step();
    check("sat3.taken_at4", 32'(taken3), 32'd1);
    check("sat2.taken_at0", 32'(pred_taken), 32'd0);
    quiet_res(32'h600, 1'b0);
    step();
    check("sat3.taken_at3", 32'(taken3), 32'd0);
    check("sat3.hit", 32'(hit3), 32'd1);

    // Reset mid-stream with an allocation in flight.
    drive_res(32'h700, 1'b1, 1'b0, 1'b1, 32'h780, 1'b0, 32'h0);
    rst = 1'b1;
    #1;
    check("mid_rst.flush", 32'(flush), 32'd0);
    step();
    step();
    rst = 1'b0;
    res_valid = 1'b0;
    check_stats("mid_rst_stats", 32'd0, 32'd0);
    check("mid_rst.hit", 32'(pred_hit), 32'd0);
    lookup("post_rst_40", 32'h40, 1'b0, 1'b0, 32'h0);
    lookup("post_rst_100", 32'h100, 1'b0, 1'b0, 32'h0);
    lookup("post_rst_300", 32'h300, 1'b0, 1'b0, 32'h0);
    lookup("post_rst_600", 32'h600, 1'b0, 1'b0, 32'h0);
    lookup("post_rst_700", 32'h700, 1'b0, 1'b0, 32'h0);

    // Statistics: eight resolves with three mispredicts, plus one non-control cycle.
    pred_pc = 32'h0;
    resolve("st_a", 32'h800, 1'b1, 1'b0, 1'b1, 32'h900, 1'b0, 32'h0, 1'b1, 32'h900);
    resolve("st_b", 32'h800, 1'b1, 1'b0, 1'b1, 32'h900, 1'b1, 32'h900, 1'b0, 32'h804);
    resolve("st_c", 32'h804, 1'b1, 1'b0, 1'b0, 32'h950, 1'b0, 32'h0, 1'b0, 32'h808);
    resolve("st_d", 32'h808, 1'b1, 1'b1, 1'b0, 32'hA00, 1'b0, 32'h0, 1'b1, 32'hA00);
    resolve("st_e", 32'h808, 1'b0, 1'b1, 1'b0, 32'hA00, 1'b1, 32'hA00, 1'b0, 32'h80C);
    resolve("st_f", 32'h800, 1'b1, 1'b0, 1'b1, 32'h900, 1'b1, 32'h904, 1'b1, 32'h900);
    resolve("st_g", 32'h80C, 1'b1, 1'b0, 1'b0, 32'h990, 1'b0, 32'h0, 1'b0, 32'h810);
    resolve("st_h", 32'h800, 1'b1, 1'b0, 1'b1, 32'h900, 1'b1, 32'h900, 1'b0, 32'h804);
    resolve("st_nonctl", 32'h900, 1'b0, 1'b0, 1'b1, 32'h123, 1'b0, 32'h0, 1'b0, 32'h904);
    check_stats("stats_final", 32'd8, 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
